// File: rtl/tl_execute.sv
// EX stage of the MIPS pipeline: operand selection, ALU, branch target and write-register
// selection, all registered into the EX/MEM latch with stall/flush support.
module tl_execute #(
    parameter int unsigned len                   = 32,
    parameter int unsigned NB_address_registros  = 5,
    parameter int unsigned NB_ALU_CONTROL        = 4,
    parameter int unsigned NB_CTRL_WB            = 2,
    parameter int unsigned NB_CTRL_MEM           = 3,
    parameter int unsigned NB_CTRL_EX            = 7
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_stall,
    input  logic                            i_flush,
    input  logic [len-1:0]                  i_adder_pc,
    input  logic [len-1:0]                  i_dato1,
    input  logic [len-1:0]                  i_dato2,
    input  logic [len-1:0]                  i_sign_extend,
    input  logic [NB_address_registros-1:0] i_rt,
    input  logic [NB_address_registros-1:0] i_rd,
    input  logic [NB_address_registros-1:0] i_shamt,
    input  logic [NB_CTRL_EX-1:0]           i_ctrl_ex,
    input  logic [NB_CTRL_MEM-1:0]          i_ctrl_mem,
    input  logic [NB_CTRL_WB-1:0]           i_ctrl_wb,
    output logic [len-1:0]                  o_alu_result,
    output logic                            o_zero,
    output logic [len-1:0]                  o_branch_target,
    output logic [len-1:0]                  o_write_data,
    output logic [NB_address_registros-1:0] o_write_reg,
    output logic [NB_CTRL_MEM-1:0]          o_ctrl_mem,
    output logic [NB_CTRL_WB-1:0]           o_ctrl_wb
);

    // i_ctrl_ex = {reg_dst, alu_src, shift_var, alu_ctrl}
    logic                            reg_dst;
    logic                            alu_src;
    logic                            shift_var;
    logic [NB_ALU_CONTROL-1:0]       alu_ctrl;

    assign reg_dst   = i_ctrl_ex[NB_CTRL_EX-1];
    assign alu_src   = i_ctrl_ex[NB_CTRL_EX-2];
    assign shift_var = i_ctrl_ex[NB_CTRL_EX-3];
    assign alu_ctrl  = i_ctrl_ex[NB_ALU_CONTROL-1:0];

    logic [len-1:0]                  op_a;
    logic [len-1:0]                  op_b;
    logic [4:0]                      shamt;
    logic [len-1:0]                  alu_res;
    logic [len-1:0]                  branch_target;
    logic [NB_address_registros-1:0] write_reg;
    logic                            slt_s;
    logic                            slt_u;

    assign op_a  = i_dato1;
    assign op_b  = alu_src ? i_sign_extend : i_dato2;
    assign shamt = shift_var ? i_dato1[4:0] : i_shamt[4:0];
    assign slt_s = $signed(op_a) < $signed(op_b);
    assign slt_u = op_a < op_b;

    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            4'b0000: alu_res = op_a & op_b;
            4'b0001: alu_res = op_a | op_b;
            4'b0010: alu_res = op_a + op_b;
            4'b0011: alu_res = op_a ^ op_b;
            4'b0100: alu_res = ~(op_a | op_b);
            4'b0110: alu_res = op_a - op_b;
            4'b0111: alu_res = {{(len-1){1'b0}}, slt_s};
            4'b1000: alu_res = op_b << shamt;
            4'b1001: alu_res = op_b >> shamt;
            4'b1010: alu_res = $unsigned($signed(op_b) >>> shamt);
            4'b1011: alu_res = len'(op_b[15:0]) << 16;
            4'b1100: alu_res = {{(len-1){1'b0}}, slt_u};
            default: alu_res = '0;
        endcase
    end

    assign branch_target = i_adder_pc + (i_sign_extend << 2);
    assign write_reg     = reg_dst ? i_rd : i_rt;

    // Flush clears data too, so a bubble looks identical to a reset latch.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            o_alu_result    <= '0;
            o_zero          <= 1'b0;
            o_branch_target <= '0;
            o_write_data    <= '0;
            o_write_reg     <= '0;
            o_ctrl_mem      <= '0;
            o_ctrl_wb       <= '0;
        end else if (!i_stall) begin
            o_alu_result    <= alu_res;
            o_zero          <= (alu_res == '0);
            o_branch_target <= branch_target;
            o_write_data    <= i_dato2;
            o_write_reg     <= write_reg;
            o_ctrl_mem      <= i_ctrl_mem;
            o_ctrl_wb       <= i_ctrl_wb;
        end
    end

endmodule

// File: tb/tb_tl_execute.sv
// Directed-vector bench for tl_execute with hand-computed expectations.
module tb_tl_execute;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [31:0] adder_pc, dato1, dato2, sign_extend;
    logic [4:0]  rt, rd, shamt;
    logic [6:0]  ctrl_ex;
    logic [2:0]  ctrl_mem;
    logic [1:0]  ctrl_wb;
    logic [31:0] alu_result, branch_target, write_data;
    logic        zero;
    logic [4:0]  write_reg;
    logic [2:0]  ctrl_mem_q;
    logic [1:0]  ctrl_wb_q;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tl_execute dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_stall        (stall),
        .i_flush        (flush),
        .i_adder_pc     (adder_pc),
        .i_dato1        (dato1),
        .i_dato2        (dato2),
        .i_sign_extend  (sign_extend),
        .i_rt           (rt),
        .i_rd           (rd),
        .i_shamt        (shamt),
        .i_ctrl_ex      (ctrl_ex),
        .i_ctrl_mem     (ctrl_mem),
        .i_ctrl_wb      (ctrl_wb),
        .o_alu_result   (alu_result),
        .o_zero         (zero),
        .o_branch_target(branch_target),
        .o_write_data   (write_data),
        .o_write_reg    (write_reg),
        .o_ctrl_mem     (ctrl_mem_q),
        .o_ctrl_wb      (ctrl_wb_q)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Drive one instruction, then sample just after the capturing edge.
    task automatic apply(input logic [31:0] pc, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] se, input logic [4:0] t, input logic [4:0] d,
                         input logic [4:0] sh, input logic [6:0] ex, input logic [2:0] mem,
                         input logic [1:0] wb);
        adder_pc = pc; dato1 = d1; dato2 = d2; sign_extend = se;
        rt = t; rd = d; shamt = sh; ctrl_ex = ex; ctrl_mem = mem; ctrl_wb = wb;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".alu"},  alu_result, 32'h0);
        check({tag, ".zero"}, {31'b0, zero}, 32'h0);
        check({tag, ".bt"},   branch_target, 32'h0);
        check({tag, ".wd"},   write_data, 32'h0);
        check({tag, ".wr"},   {27'b0, write_reg}, 32'h0);
        check({tag, ".mem"},  {29'b0, ctrl_mem_q}, 32'h0);
        check({tag, ".wb"},   {30'b0, ctrl_wb_q}, 32'h0);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        apply(32'h4, 32'h5, 32'h7, 32'h1, 5'd2, 5'd3, 5'd0, 7'b1000010, 3'b111, 2'b11);
        check_all_zero("reset");
        rst = 1'b0;

        // R-type ADD
        apply(32'h0, 32'd5, 32'd7, 32'h0, 5'd2, 5'd3, 5'd0, 7'b1000010, 3'b000, 2'b10);
        check("add.alu", alu_result, 32'd12);
        check("add.wr", {27'b0, write_reg}, 32'd3);
        check("add.zero", {31'b0, zero}, 32'd0);
        check("add.wb", {30'b0, ctrl_wb_q}, 32'd2);

        // SUB to zero, SUB wrap, SLT vs SLTU
        apply(32'h0, 32'h1234, 32'h1234, 32'h0, 5'd1, 5'd4, 5'd0, 7'b1000110, 3'b000, 2'b10);
        check("sub0.alu", alu_result, 32'h0);
        check("sub0.zero", {31'b0, zero}, 32'd1);
        apply(32'h0, 32'h0, 32'h1, 32'h0, 5'd1, 5'd4, 5'd0, 7'b1000110, 3'b000, 2'b10);
        check("subw.alu", alu_result, 32'hFFFFFFFF);
        check("subw.zero", {31'b0, zero}, 32'd0);
        apply(32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 5'd1, 5'd4, 5'd0, 7'b1000111, 3'b000, 2'b10);
        check("slt.alu", alu_result, 32'h1);
        apply(32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 5'd1, 5'd4, 5'd0, 7'b1001100, 3'b000, 2'b10);
        check("sltu.alu", alu_result, 32'h0);
        check("sltu.zero", {31'b0, zero}, 32'd1);

        // LW / SW immediate path
        apply(32'h0, 32'h100, 32'h55, 32'hFFFFFFFC, 5'd2, 5'd7, 5'd0, 7'b0100010, 3'b100, 2'b11);
        check("lw.alu", alu_result, 32'hFC);
        check("lw.wr", {27'b0, write_reg}, 32'd2);
        check("lw.mem", {29'b0, ctrl_mem_q}, 32'b100);
        apply(32'h0, 32'h100, 32'hDEADBEEF, 32'h8, 5'd2, 5'd7, 5'd0, 7'b0100010, 3'b010, 2'b00);
        check("sw.alu", alu_result, 32'h108);
        check("sw.wd", write_data, 32'hDEADBEEF);
        check("sw.mem", {29'b0, ctrl_mem_q}, 32'b010);

        // BEQ
        apply(32'h40, 32'd9, 32'd9, 32'h10, 5'd9, 5'd0, 5'd0, 7'b0000110, 3'b001, 2'b00);
        check("beq.bt", branch_target, 32'h80);
        check("beq.zero", {31'b0, zero}, 32'd1);
        check("beq.mem", {29'b0, ctrl_mem_q}, 32'b001);

        // Shifts
        apply(32'h0, 32'h0, 32'h1, 32'h0, 5'd1, 5'd2, 5'd4, 7'b1001000, 3'b000, 2'b10);
        check("sll.alu", alu_result, 32'h10);
        apply(32'h0, 32'd31, 32'h80000000, 32'h0, 5'd1, 5'd2, 5'd0, 7'b1011010, 3'b000, 2'b10);
        check("sra.alu", alu_result, 32'hFFFFFFFF);
        apply(32'h0, 32'd0, 32'h80000000, 32'h0, 5'd1, 5'd2, 5'd4, 7'b1001001, 3'b000, 2'b10);
        check("srl.alu", alu_result, 32'h08000000);

        // Logic ops, LUI, undefined code
        apply(32'h0, 32'hF0F000FF, 32'h0FF0F00F, 32'h0, 5'd1, 5'd2, 5'd0, 7'b1000000, 3'b0, 2'b10);
        check("and.alu", alu_result, 32'h00F0000F);
        apply(32'h0, 32'hF0F000FF, 32'h0FF0F00F, 32'h0, 5'd1, 5'd2, 5'd0, 7'b1000001, 3'b0, 2'b10);
        check("or.alu", alu_result, 32'hFFF0F0FF);
        apply(32'h0, 32'hF0F000FF, 32'h0FF0F00F, 32'h0, 5'd1, 5'd2, 5'd0, 7'b1000011, 3'b0, 2'b10);
        check("xor.alu", alu_result, 32'hFF00F0F0);
        apply(32'h0, 32'hF0F000FF, 32'h0FF0F00F, 32'h0, 5'd1, 5'd2, 5'd0, 7'b1000100, 3'b0, 2'b10);
        check("nor.alu", alu_result, 32'h000F0F00);
        apply(32'h0, 32'h0, 32'h0, 32'h1234ABCD, 5'd1, 5'd2, 5'd0, 7'b0101011, 3'b0, 2'b10);
        check("lui.alu", alu_result, 32'hABCD0000);
        apply(32'h0, 32'h5, 32'h7, 32'h0, 5'd1, 5'd2, 5'd0, 7'b1001101, 3'b0, 2'b10);
        check("undef.alu", alu_result, 32'h0);
        check("undef.zero", {31'b0, zero}, 32'd1);

        // Hazards: stall holds, flush beats stall, reset clears
        apply(32'h20, 32'd5, 32'd7, 32'h1, 5'd2, 5'd3, 5'd0, 7'b1000010, 3'b100, 2'b10);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply(32'h100 + i, 32'd100 + i, 32'd1, 32'h2, 5'd8, 5'd9, 5'd0, 7'b1000110, 3'b011,
                  2'b01);
            check("stall.alu", alu_result, 32'd12);
            check("stall.wr", {27'b0, write_reg}, 32'd3);
            check("stall.wb", {30'b0, ctrl_wb_q}, 32'b10);
            check("stall.bt", branch_target, 32'h24);
        end
        flush = 1'b1;
        apply(32'h100, 32'd100, 32'd1, 32'h2, 5'd8, 5'd9, 5'd0, 7'b1000110, 3'b011, 2'b01);
        check_all_zero("flush");
        flush = 1'b0; stall = 1'b0;
        apply(32'h10, 32'd3, 32'd1, 32'h1, 5'd8, 5'd9, 5'd0, 7'b1000110, 3'b011, 2'b01);
        check("post.alu", alu_result, 32'd2);
        check("post.wb", {30'b0, ctrl_wb_q}, 32'b01);
        rst = 1'b1;
        apply(32'h10, 32'd3, 32'd1, 32'h1, 5'd8, 5'd9, 5'd0, 7'b1000110, 3'b011, 2'b01);
        check_all_zero("rst");
        rst = 1'b0;
        apply(32'h10, 32'd3, 32'd1, 32'h1, 5'd8, 5'd9, 5'd0, 7'b1000010, 3'b011, 2'b01);
        check("rel.alu", alu_result, 32'd4);
        check("rel.mem", {29'b0, ctrl_mem_q}, 32'b011);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
